// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fpu_pkg
// Description : Types and widths shared by the memory controller, the FPU
//               operand buffer and its sub-blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    // Width of one operand word as read out of RAM
    localparam int WORD_W        = 32;
    // One FIFO entry carries an (opa, opb) pair
    localparam int PAIR_W        = 2 * WORD_W;
    // Batch length width, matches the memory controller's length field
    localparam int DEFAULT_CNT_W = 6;

    // Issue FSM state encoding
    typedef enum logic [1:0] {
        OB_IDLE = 2'b00,
        OB_RUN  = 2'b01,
        OB_WAIT = 2'b10,
        OB_DONE = 2'b11
    } ob_state_t;

endpackage
`default_nettype wire

// File: rtl/operand_pair_fifo.sv
`default_nettype none
// ============================================================================
// Module      : operand_pair_fifo
// Description : Circular FIFO of operand pairs. Natural-wrap pointers plus an
//               occupancy count. A push into a full FIFO is accepted only
//               when a pop frees the head slot in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_pair_fifo #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_pop_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [PTR_W:0]    o_count
);

    localparam logic [PTR_W:0] c_full_cnt = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full     = (r_count == c_full_cnt);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot the push lands in when full
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pair storage; contents are only meaningful behind the count
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_operand_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fpu_operand_buffer
// Description : Pairs the memory controller's word stream into (opa, opb)
//               operands, buffers the pairs and issues them to the FPU with a
//               start/ready/done handshake, counting completions per batch.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_operand_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int CNT_W = fpu_pkg::DEFAULT_CNT_W
) (
    input  logic                        ob_clk,
    input  logic                        ob_reset_n,
    input  logic                        ob_word_valid,
    input  logic [fpu_pkg::WORD_W-1:0]  ob_word_in,
    input  logic                        ob_start,
    input  logic [CNT_W-1:0]            ob_pair_count,
    input  logic                        ob_fpu_ready,
    input  logic                        ob_fpu_done,
    output logic [fpu_pkg::WORD_W-1:0]  ob_fpu_opa,
    output logic [fpu_pkg::WORD_W-1:0]  ob_fpu_opb,
    output logic                        ob_fpu_start,
    output logic                        ob_full,
    output logic                        ob_empty,
    output logic                        ob_busy,
    output logic                        ob_batch_done,
    output logic                        ob_overflow
);

    import fpu_pkg::*;

    // Pairing state
    logic              r_half;
    logic [WORD_W-1:0] r_hold_opa;
    logic              w_push;
    logic [PAIR_W-1:0] w_pair;

    // FIFO interface
    logic              w_pop;
    logic [PAIR_W-1:0] w_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [PTR_W:0]    w_fifo_count;
    logic              r_overflow;

    // Issue FSM
    ob_state_t         r_state;
    logic [CNT_W-1:0]  r_batch_len;
    logic [CNT_W-1:0]  r_issue_cnt;
    logic [CNT_W-1:0]  w_issue_next;
    logic [WORD_W-1:0] r_fpu_opa;
    logic [WORD_W-1:0] r_fpu_opb;
    logic              r_fpu_start;
    logic              r_batch_done;

    // Second word of a pair completes it and is pushed in the same cycle
    assign w_push = ob_word_valid && r_half;
    assign w_pair = {r_hold_opa, ob_word_in};

    // Pop only when the FSM actually issues the head pair
    assign w_pop = (r_state == OB_RUN) && (r_batch_len != '0) &&
                   (w_fifo_count != '0) && ob_fpu_ready;

    assign w_issue_next = r_issue_cnt + 1'b1;

    // Word slot selection; runs in every FSM state so the buffer can fill early
    always_ff @(posedge ob_clk or negedge ob_reset_n) begin
        if (!ob_reset_n) begin
            r_half     <= 1'b0;
            r_hold_opa <= '0;
        end else if (ob_word_valid) begin
            if (!r_half) begin
                r_hold_opa <= ob_word_in;
                r_half     <= 1'b1;
            end else begin
                // Pair is either stored or dropped; next word starts a new pair
                r_half <= 1'b0;
            end
        end
    end

    // Sticky record of a completed pair lost to a full buffer
    always_ff @(posedge ob_clk or negedge ob_reset_n) begin
        if (!ob_reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    operand_pair_fifo #(
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .DATA_W (PAIR_W)
    ) u_pair_fifo (
        .clk         (ob_clk),
        .rst_n       (ob_reset_n),
        .i_push      (w_push),
        .i_push_data (w_pair),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // Issue FSM with registered operand, start and batch-done outputs
    always_ff @(posedge ob_clk or negedge ob_reset_n) begin
        if (!ob_reset_n) begin
            r_state      <= OB_IDLE;
            r_batch_len  <= '0;
            r_issue_cnt  <= '0;
            r_fpu_opa    <= '0;
            r_fpu_opb    <= '0;
            r_fpu_start  <= 1'b0;
            r_batch_done <= 1'b0;
        end else begin
            r_fpu_start  <= 1'b0;
            r_batch_done <= 1'b0;
            case (r_state)
                OB_IDLE: begin
                    if (ob_start) begin
                        r_batch_len <= ob_pair_count;
                        r_issue_cnt <= '0;
                        r_state     <= OB_RUN;
                    end
                end
                OB_RUN: begin
                    if (r_batch_len == '0) begin
                        r_state <= OB_DONE;
                    end else if (w_pop) begin
                        r_fpu_opa   <= w_head[PAIR_W-1:WORD_W];
                        r_fpu_opb   <= w_head[WORD_W-1:0];
                        r_fpu_start <= 1'b1;
                        r_state     <= OB_WAIT;
                    end
                end
                OB_WAIT: begin
                    if (ob_fpu_done) begin
                        r_issue_cnt <= w_issue_next;
                        r_state     <= (w_issue_next == r_batch_len) ? OB_DONE : OB_RUN;
                    end
                end
                OB_DONE: begin
                    r_batch_done <= 1'b1;
                    r_state      <= OB_IDLE;
                end
                default: r_state <= OB_IDLE;
            endcase
        end
    end

    assign ob_fpu_opa    = r_fpu_opa;
    assign ob_fpu_opb    = r_fpu_opb;
    assign ob_fpu_start  = r_fpu_start;
    assign ob_full       = w_fifo_full;
    assign ob_empty      = w_fifo_empty;
    assign ob_busy       = (r_state != OB_IDLE);
    assign ob_batch_done = r_batch_done;
    assign ob_overflow   = r_overflow;

endmodule
`default_nettype wire

// File: doc/fpu_operand_buffer.md
Name: fpu_operand_buffer

Overview:
- Downstream neighbour of the memory controller.
- Receives the 32-bit word stream the memory controller reads out of RAM, pairs consecutive words into (opa, opb) operand pairs, and buffers the pairs in a small FIFO.
- Issues each pair to the FPU with a start/ready/done handshake, counts completed operations for a batch, and signals batch completion.

Parameters:
- DEPTH, 4, number of operand pairs held; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width.
- CNT_W, 6, width of the batch pair counter; matches the memory controller's 6-bit length field.

Ports:
- ob_clk  in  1  clock, rising edge.
- ob_reset_n  in  1  reset; asynchronous, active-low.
- ob_word_valid  in  1  ob_word_in carries a valid word this cycle.
- ob_word_in  in  32  operand word from the memory controller.
- ob_start  in  1  begin a batch; sampled only in IDLE.
- ob_pair_count  in  CNT_W  number of pairs in the batch; latched on an accepted ob_start.
- ob_fpu_ready  in  1  FPU can accept an operation.
- ob_fpu_done  in  1  FPU finished the current operation; one-cycle pulse.
- ob_fpu_opa  out  32  operand A to the FPU, registered.
- ob_fpu_opb  out  32  operand B to the FPU, registered.
- ob_fpu_start  out  1  one-cycle pulse; operands are valid in the same cycle.
- ob_full  out  1  FIFO holds DEPTH pairs.
- ob_empty  out  1  FIFO holds 0 pairs.
- ob_busy  out  1  issue FSM is not in IDLE.
- ob_batch_done  out  1  one-cycle pulse when the batch completes.
- ob_overflow  out  1  sticky; set when a completed pair is dropped.

Behaviour:
- Reset (ob_reset_n low, asynchronous): all outputs 0 except ob_empty=1. Pointers, count, half flag and issue counter are cleared. FSM goes to IDLE.
- Reset asserted mid-operation discards buffered pairs and any half pair.
- Pairing:
  - A 1-bit half flag selects the word slot. A valid word with half=0 is stored in the opa holding register and half becomes 1.
  - A valid word with half=1 completes the pair {hold_opa, ob_word_in}. The pair is pushed the same cycle and half returns to 0.
  - Pairing runs in every FSM state, so the buffer may fill ahead of ob_start.
- FIFO:
  - Circular, with PTR_W-bit read and write pointers that wrap naturally, plus a count register of PTR_W+1 bits.
  - ob_full = (count==DEPTH); ob_empty = (count==0).
  - Push when full with no pop in the same cycle: the pair is dropped, ob_overflow is set (cleared only by reset), and half returns to 0.
  - Push and pop in the same cycle are both allowed, including when full, and leave the count unchanged. A same-cycle pop frees the slot, so no overflow occurs.
- Issue FSM: IDLE, RUN, WAIT, DONE.
  - IDLE: on ob_start, latch ob_pair_count, clear the issue counter, go to RUN. ob_start is ignored in all other states.
  - RUN: if the latched count is 0, go to DONE. Otherwise, when !ob_empty && ob_fpu_ready, register the head pair onto ob_fpu_opa/opb, pulse ob_fpu_start, pop, and go to WAIT.
  - WAIT: on ob_fpu_done, increment the issue counter. Go to DONE if the incremented value equals the latched count, else return to RUN. ob_fpu_done outside WAIT is ignored.
  - DONE: pulse ob_batch_done for one cycle, then go to IDLE.
- Latency:
  - Pair head to ob_fpu_start is 1 cycle after the RUN condition is sampled.
  - Completing word to earliest issue is 2 cycles: push at edge n, issue decision at edge n+1.
  - ob_fpu_done to next ob_fpu_start is at least 2 cycles.
- ob_fpu_opa/opb hold their last value between issues.
- ob_busy = (state != IDLE).

Decomposition:
- Shared package (fpu_pkg):
  - FSM state encodings: OB_IDLE=2'b00, OB_RUN=2'b01, OB_WAIT=2'b10, OB_DONE=2'b11.
  - WORD_W=32 and the default CNT_W, shared with the memory controller.
- One sub-module: operand_pair_fifo (64-bit wide, DEPTH deep, push/pop/full/empty/count).
- Pairing logic and the issue FSM stay in the top.

Test Plan:
- Basic batch: ob_pair_count=2, stream words 0x3F800000, 0x40000000, 0x40400000, 0x40800000; FPU always ready, done 3 cycles after start.
  - Required: two ob_fpu_start pulses with (0x3F800000, 0x40000000) then (0x40400000, 0x40800000), followed by a single ob_batch_done pulse and ob_busy=0.
- Fill ahead with overflow: with FSM in IDLE, send 10 words.
  - Required: ob_full=1 after 8 words; pair 5 dropped and ob_overflow=1.
  - Then ob_start with count 4 and FPU ready: the first 4 pairs issue in order and ob_empty=1.
- Simultaneous push/pop: FIFO full, FSM in RUN, ob_fpu_ready=1 in the same cycle a pair completes.
  - Required: count stays 4 and ob_overflow stays 0.
- Zero-length batch: ob_start with ob_pair_count=0.
  - Required: no ob_fpu_start; ob_batch_done pulses exactly 2 cycles after the start edge.
- Backpressure and stray done: hold ob_fpu_ready=0 for 5 cycles with the FIFO non-empty, then raise it. Also pulse ob_fpu_done while in RUN.
  - Required: no issue while ready is low; issue 1 cycle after ready rises; the stray done has no effect on the issue counter.
- Mid-operation reset: ob_reset_n low in WAIT with 3 pairs buffered and half=1.
  - Required: outputs return to reset values immediately (asynchronous), and the next word received is treated as opa.
